// File: rtl/aes_uart_framer_if.sv
// Byte-stream and AES-core signals of the framer. The framer takes the master side;
// the UART and the AES core sit on the slave side.
interface aes_uart_framer_if #(
  parameter int BLOCK_BYTES = 16
);
  localparam int BLOCK_BITS = 8 * BLOCK_BYTES;

  logic                  rx_ready;
  logic [7:0]            rx_data;
  logic                  rx_clear;
  logic                  tx_busy;
  logic                  tx_begin;
  logic [7:0]            tx_data;
  logic                  aes_start;
  logic                  aes_enc_dec;
  logic [2:0]            aes_key_size;
  logic [BLOCK_BITS-1:0] aes_message_in;
  logic                  aes_done;
  logic [BLOCK_BITS-1:0] aes_message_out;

  modport master (
    input  rx_ready, rx_data, tx_busy, aes_done, aes_message_out,
    output rx_clear, tx_begin, tx_data, aes_start, aes_enc_dec, aes_key_size, aes_message_in
  );

  modport slave (
    output rx_ready, rx_data, tx_busy, aes_done, aes_message_out,
    input  rx_clear, tx_begin, tx_data, aes_start, aes_enc_dec, aes_key_size, aes_message_in
  );
endinterface

// File: rtl/aes_uart_framer.sv
// Frames a command byte plus BLOCK_BYTES payload bytes from the UART into one AES
// block and streams a status byte plus the AES result back out.
module aes_uart_framer #(
  parameter int         BLOCK_BYTES = 16,
  parameter int         RX_TIMEOUT  = 1000000,
  parameter int         AES_TIMEOUT = 4096,
  parameter logic [7:0] STATUS_OK   = 8'h5A,
  parameter logic [7:0] STATUS_ERR  = 8'hEE
) (
  input  logic              clock,
  input  logic              reset,
  aes_uart_framer_if.master bus,
  output logic              busy,
  output logic              frame_error
);
  localparam int BLOCK_BITS  = 8 * BLOCK_BYTES;
  localparam int COUNT_W     = $clog2(BLOCK_BYTES + 1);
  localparam int TIMEOUT_MAX = (RX_TIMEOUT > AES_TIMEOUT) ? RX_TIMEOUT : AES_TIMEOUT;
  localparam int TIMER_W     = $clog2(TIMEOUT_MAX + 1);
  localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(BLOCK_BYTES - 1);
  localparam logic [TIMER_W-1:0] RX_LIMIT  = TIMER_W'(RX_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] AES_LIMIT = TIMER_W'(AES_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CMD_ACK, RX_WAIT, RX_ACK, AES_GO, AES_WAIT, TX_WAIT, TX_LOAD, TX_CHECK, ERR
  } stateType;

  typedef enum logic [1:0] {PHASE_STATUS, PHASE_DATA, PHASE_ERROR} phaseType;

  stateType             state;
  phaseType             phase;
  logic [7:0]           command;
  logic [COUNT_W-1:0]   byteCount;
  logic [TIMER_W-1:0]   timer;

  // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      phase              <= PHASE_STATUS;
      command            <= '0;
      byteCount          <= '0;
      timer              <= '0;
      busy               <= 1'b0;
      frame_error        <= 1'b0;
      bus.rx_clear       <= 1'b0;
      bus.tx_begin       <= 1'b0;
      bus.tx_data        <= '0;
      bus.aes_start      <= 1'b0;
      bus.aes_enc_dec    <= 1'b0;
      bus.aes_key_size   <= '0;
      // NOTE: the payload lives in flops, not RAM, so it is reset with everything else.
      bus.aes_message_in <= '0;
    end else begin
      bus.rx_clear  <= 1'b0;
      bus.aes_start <= 1'b0;
      frame_error   <= 1'b0;
      case (state)
        IDLE: if (bus.rx_ready) begin
          command      <= bus.rx_data;
          bus.rx_clear <= 1'b1;
          busy         <= 1'b1;
          state        <= CMD_ACK;
        end
        CMD_ACK: if (command[7:4] == 4'hA) begin
          bus.aes_enc_dec  <= command[0];
          bus.aes_key_size <= command[3:1];
          byteCount        <= '0;
          timer            <= '0;
          state            <= RX_WAIT;
        end else begin
          frame_error <= 1'b1;
          state       <= ERR;
        end
        RX_WAIT: if (bus.rx_ready) begin
          bus.aes_message_in[BLOCK_BITS-1-8*int'(byteCount) -: 8] <= bus.rx_data;
          bus.rx_clear <= 1'b1;
          state        <= RX_ACK;
        end else if (timer == RX_LIMIT) begin
          frame_error <= 1'b1;
          state       <= ERR;
        end else begin
          timer <= timer + 1'b1;
        end
        RX_ACK: begin
          timer <= '0;
          if (byteCount == LAST_SLOT) begin
            byteCount <= '0;
            state     <= AES_GO;
          end else begin
            byteCount <= byteCount + 1'b1;
            state     <= RX_WAIT;
          end
        end
        AES_GO: begin
          bus.aes_start <= 1'b1;
          timer         <= '0;
          state         <= AES_WAIT;
        end
        // aes_done may still hold the previous block's result during the start pulse.
        AES_WAIT: if (!bus.aes_start && bus.aes_done) begin
          bus.tx_data  <= STATUS_OK;
          bus.tx_begin <= 1'b1;
          phase        <= PHASE_STATUS;
          state        <= TX_LOAD;
        end else if (timer == AES_LIMIT) begin
          frame_error <= 1'b1;
          state       <= ERR;
        end else begin
          timer <= timer + 1'b1;
        end
        TX_WAIT: if (!bus.tx_busy) begin
          bus.tx_data  <= bus.aes_message_out[BLOCK_BITS-1-8*int'(byteCount) -: 8];
          bus.tx_begin <= 1'b1;
          state        <= TX_LOAD;
        end
        TX_LOAD: begin
          bus.tx_begin <= 1'b1;
          state        <= TX_CHECK;
        end
        TX_CHECK: if (bus.tx_busy) begin
          bus.tx_begin <= 1'b0;
          if (phase == PHASE_STATUS) begin
            phase     <= PHASE_DATA;
            byteCount <= '0;
            state     <= TX_WAIT;
          end else if (phase == PHASE_ERROR || byteCount == LAST_SLOT) begin
            byteCount <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            byteCount <= byteCount + 1'b1;
            state     <= TX_WAIT;
          end
        end
        ERR: if (!bus.tx_busy) begin
          bus.tx_data  <= STATUS_ERR;
          bus.tx_begin <= 1'b1;
          phase        <= PHASE_ERROR;
          state        <= TX_LOAD;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
